// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned DW = 2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/twoToOneMux.sv
// Two-input, 2-bit data multiplexer; sel = 0 picks a, sel = 1 picks b.
module twoToOneMux
  import mux_arb_pkg::*;
(
  input  data_t a,
  input  data_t b,
  input  logic  sel,
  output data_t out_c
);

  assign out_c = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 2-bit output register between requesters A and B
// by steering twoToOneMux; per-requester saturating transfer counters for debug.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  data_t         a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  data_t         b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output data_t         out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sel,
  output logic          src,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  state_e state_q, state_d;
  data_t  out_data_q;
  logic   src_q;
  logic   last_q;

  logic   load_c;
  logic   grant_any_c;
  logic   grant_c;
  logic   xfer_c;
  data_t  mux_out_c;

  // Grant, handshake and next-state decode; ready is suppressed while in reset.
  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    grant_any_c = 1'b0;
    grant_c     = SRC_A;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    sel         = last_q;
    xfer_c      = 1'b0;

    load_c = (state_q == EMPTY) || out_ready;

    if (a_valid && b_valid) begin
      grant_c = ~last_q;
    end else if (b_valid) begin
      grant_c = SRC_B;
    end else begin
      grant_c = SRC_A;
    end

    grant_any_c = rst_n && load_c && (a_valid || b_valid);

    if (grant_any_c) begin
      sel     = grant_c;
      a_ready = (grant_c == SRC_A);
      b_ready = (grant_c == SRC_B);
      xfer_c  = 1'b1;
    end else if (!rst_n) begin
      sel = SRC_B;
    end

    if (xfer_c) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word register; src and last only move on an accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
      src_q      <= SRC_A;
      last_q     <= SRC_B;
    end else if (xfer_c) begin
      out_data_q <= mux_out_c;
      src_q      <= grant_c;
      last_q     <= grant_c;
    end
  end

  twoToOneMux u_mux (
    .a     (a_data),
    .b     (b_data),
    .sel   (sel),
    .out_c (mux_out_c)
  );

  sat_counter #(.CW(CW)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (a_ready),
    .clr   (1'b0),
    .cnt   (cnt_a)
  );

  sat_counter #(.CW(CW)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (b_ready),
    .clr   (1'b0),
    .cnt   (cnt_b)
  );

  assign out_data  = out_data_q;
  assign out_valid = (state_q == FULL);
  assign src       = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter, built with CW = 2 to reach saturation.
module tb_mux_rr_arbiter;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic [1:0]    a_data;
  logic          a_valid;
  logic          a_ready;
  logic [1:0]    b_data;
  logic          b_valid;
  logic          b_ready;
  logic [1:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sel;
  logic          src;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  int tests;
  int failed;

  mux_rr_arbiter #(.CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .src       (src),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [1:0] words [5];

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    a_data    = 2'b01;
    b_data    = 2'b10;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    out_ready = 1'b1;

    // Reset held two cycles with both requesters valid
    step();
    step();
    check("rst_a_ready", int'(a_ready), 0);
    check("rst_b_ready", int'(b_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_src", int'(src), 0);
    check("rst_cnt_a", int'(cnt_a), 0);
    check("rst_cnt_b", int'(cnt_b), 0);
    check("rst_sel", int'(sel), 1);
    rst_n = 1'b1;
    #1;
    check("post_rst_a_ready", int'(a_ready), 1);
    check("post_rst_b_ready", int'(b_ready), 0);
    check("post_rst_sel", int'(sel), 0);
    step();
    check("first_out_valid", int'(out_valid), 1);
    check("first_out_data", int'(out_data), 1);
    check("first_src", int'(src), 0);
    check("second_b_ready", int'(b_ready), 1);
    check("second_a_ready", int'(a_ready), 0);

    // Single source: A streams 01, 10, 11
    do_reset();
    a_valid = 1'b1;
    b_valid = 1'b0;
    words[0] = 2'b01;
    words[1] = 2'b10;
    words[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a_data = words[i];
      #1;
      check("single_a_ready", int'(a_ready), 1);
      step();
      check("single_out_data", int'(out_data), int'(words[i]));
      check("single_out_valid", int'(out_valid), 1);
      check("single_src", int'(src), 0);
    end
    a_valid = 1'b0;
    step();
    check("single_drain_valid", int'(out_valid), 0);
    check("single_cnt_a", int'(cnt_a), 3);
    check("single_cnt_b", int'(cnt_b), 0);

    // Contention: strict A/B alternation
    do_reset();
    a_data  = 2'b01;
    b_data  = 2'b10;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("cont_out_data", int'(out_data), (i % 2 == 0) ? 1 : 2);
      check("cont_src", int'(src), i % 2);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    check("cont_cnt_a", int'(cnt_a), 3);
    check("cont_cnt_b", int'(cnt_b), 3);

    // Backpressure: held word stays, readies low, no bubble on release
    do_reset();
    a_data  = 2'b11;
    a_valid = 1'b1;
    step();
    check("bp_first_data", int'(out_data), 3);
    out_ready = 1'b0;
    a_data    = 2'b01;
    b_data    = 2'b10;
    b_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_a_ready", int'(a_ready), 0);
      check("bp_b_ready", int'(b_ready), 0);
      step();
      check("bp_out_data", int'(out_data), 3);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_src", int'(src), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_b_ready", int'(b_ready), 1);
    check("bp_rel_a_ready", int'(a_ready), 0);
    step();
    b_valid = 1'b0;
    check("bp_rel_out_data", int'(out_data), 2);
    check("bp_rel_out_valid", int'(out_valid), 1);
    check("bp_rel_src", int'(src), 1);
    step();
    a_valid = 1'b0;
    check("bp_next_out_data", int'(out_data), 1);
    check("bp_next_src", int'(src), 0);
    step();
    check("bp_drain_valid", int'(out_valid), 0);

    // Saturation: five A transfers into a 2-bit counter
    do_reset();
    words[0] = 2'b01;
    words[1] = 2'b10;
    words[2] = 2'b11;
    words[3] = 2'b00;
    words[4] = 2'b01;
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = words[i];
      #1;
      check("sat_a_ready", int'(a_ready), 1);
      step();
      check("sat_out_data", int'(out_data), int'(words[i]));
      check("sat_out_valid", int'(out_valid), 1);
      check("sat_cnt_a", int'(cnt_a), (i + 1 > 3) ? 3 : i + 1);
    end
    a_valid = 1'b0;
    step();
    check("sat_final_cnt_a", int'(cnt_a), 3);

    // Mid-operation reset while holding B's word
    do_reset();
    b_data  = 2'b10;
    b_valid = 1'b1;
    step();
    check("mid_src_b", int'(src), 1);
    check("mid_full", int'(out_valid), 1);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    a_data    = 2'b01;
    a_valid   = 1'b1;
    #1;
    check("mid_rst_a_ready", int'(a_ready), 0);
    check("mid_rst_b_ready", int'(b_ready), 0);
    check("mid_rst_sel", int'(sel), 1);
    step();
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_cnt_b", int'(cnt_b), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rel_a_ready", int'(a_ready), 1);
    check("mid_rel_b_ready", int'(b_ready), 0);
    step();
    check("mid_rel_out_data", int'(out_data), 1);
    check("mid_rel_src", int'(src), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 2-bit output channel between two requesters (A, B) by sequencing the select of the team's `twoToOneMux`. Requesters present data with valid/ready handshakes. The block picks a winner each cycle the output can accept data and captures the selected word into a one-entry output register. Per-requester transfer counters provide visibility for debug and fairness checks.

## Interface
- `CW`, default 8: width of the per-requester transfer counters.
- Data width is fixed at 2 bits, matching `twoToOneMux`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `a_data` in 2: requester A data.
- `a_valid` in 1: A has data.
- `a_ready` out 1: A word accepted this cycle when `a_valid & a_ready`.
- `b_data` in 2: requester B data.
- `b_valid` in 1: B has data.
- `b_ready` out 1: B word accepted this cycle when `b_valid & b_ready`.
- `out_data` out 2: registered output word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: downstream consumes when `out_valid & out_ready`.
- `sel` out 1: mux select for the current grant; 0 = A, 1 = B (combinational).
- `src` out 1: source of the word held in `out_data` (registered).
- `cnt_a` out CW: accepted-A count, saturating.
- `cnt_b` out CW: accepted-B count, saturating.

## Operation
- **States:**
  - `EMPTY`: `out_valid` = 0.
  - `FULL`: `out_valid` = 1. `src` identifies the owner.
- **Load enable:** `load = !out_valid | out_ready`. The register can take a new word even in the same cycle the current word drains.
- **Grant, evaluated only when `load` = 1:**
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester not named by `last`.
  - Neither valid: no grant.
- **Ready outputs:**
  - `a_ready = load & grant_a`.
  - `b_ready = load & grant_b`.
  - At most one is high in any cycle.
  - Ready never depends on the requester's own valid beyond the grant decision.
- **`sel`:**
  - Equals the grant when a grant exists.
  - Otherwise holds `last`.
  - Drives `twoToOneMux` `sel`; the mux output feeds the `out_data` register D input.
- **On a transfer:** `out_data` <= mux output, `src` <= grant, `last` <= grant, state `FULL`.
- **Drain without a new transfer:** state `EMPTY`. `out_data` and `src` hold their values and are don't-care while `out_valid` = 0.
- **Counters:** `cnt_a` increments on each A transfer and `cnt_b` on each B transfer. Each stops at 2^CW−1 (no wrap).
- **Requester rule:** a requester keeps `valid` and `data` stable until accepted. The arbiter never drops or duplicates a word.

## Timing
- **Reset (`rst_n` = 0 at a clock edge), regardless of current state:**
  - `out_valid` = 0, `out_data` = 0, `src` = 0, `cnt_a` = `cnt_b` = 0.
  - `last` = 1, so A wins the first contention.
  - Any held word is discarded.
- **During reset:** `a_ready` = `b_ready` = 0. `sel` = 1, since it follows `last` when there is no grant.
- **Latency:** a word accepted in cycle N appears with `out_valid` = 1 in cycle N+1.
- **Throughput:** 1 word/cycle while `out_ready` = 1.
- **Contention:** both valid every cycle with `out_ready` = 1 gives a strict alternation A, B, A, B…
- **Backpressure:** `out_valid` = 1 and `out_ready` = 0 gives `a_ready` = `b_ready` = 0. `out_data` and `src` are held and `last` is unchanged.
- **Simultaneous events:** a drain and a new accept in the same cycle keep the state in `FULL` with the new word and no bubble.
- **Counter saturation:** a transfer at the maximum count still completes; only the counter holds.

## Structure
- Shared package `mux_arb_pkg`:
  - `SRC_A` = 1'b0, `SRC_B` = 1'b1.
  - State enum `{EMPTY, FULL}`.
  - Data width constant 2.
- Sub-modules:
  - One instance of `twoToOneMux` for data selection.
  - One `sat_counter` (parameter CW, inputs `inc`/`clr`) instantiated twice.
- Arbitration, the ready logic and the output register live in the top level.

## Test plan
- **Reset:** `rst_n` low 2 cycles with both valid → `a_ready` = `b_ready` = 0, `out_valid` = 0, counters 0. After release, A is granted first.
- **Single source:** A sends 2'b01, 2'b10, 2'b11 back-to-back with `out_ready` = 1 → `out_data` 01, 10, 11 on consecutive cycles one cycle later, `src` = 0, `cnt_a` = 3.
- **Contention:** A holds 2'b01 and B holds 2'b10, both always valid, 6 cycles → `out_data` alternates 01, 10, 01, 10, 01, 10, ending with `cnt_a` = `cnt_b` = 3.
- **Backpressure:** `out_ready` = 0 for 4 cycles while `out_valid` = 1 → both readies low, `out_data` stable. On release, the next word follows with no bubble.
- **Saturation:** CW = 2 with 5 A transfers → `cnt_a` = 3, and all 5 words are delivered.
- **Mid-operation reset:** reset asserted while `FULL` with B's word → next cycle `out_valid` = 0. After release with both valid, A wins first.
